// File: rtl/ls_counter_pkg.sv
// Shared definitions for the 74LS161-style counter family.
// FSM state encodings and default width used by the up and down counters.
package ls_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/ls161_down_timer.sv
// Loadable synchronous down-counter/timer with ripple borrow,
// one-cycle terminal-count pulse, and one-shot or auto-reload modes.
module ls161_down_timer
    import ls_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             RELOAD,
    output logic [WIDTH-1:0] Q,
    output logic             RBO,
    output logic             TC_PULSE,
    output logic             BUSY
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             cnt_en;
    logic             q_zero;

    assign cnt_en = ENP & ENT;
    assign q_zero = (q_q == ZERO);

    // Next-state logic: load beats count; TC_PULSE defaults low every edge.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        tc_d    = 1'b0;
        if (!LOAD_n) begin
            q_d     = D;
            r_d     = D;
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_RUN: begin
                    if (cnt_en) begin
                        if (!q_zero) begin
                            q_d = q_q - ONE;
                        end else begin
                            tc_d = 1'b1;
                            if (RELOAD) begin
                                q_d = r_q;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_RUN);
    end

    // State registers with synchronous active-high clear.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            q_q     <= ZERO;
            r_q     <= ZERO;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign Q        = q_q;
    assign TC_PULSE = tc_q;
    assign BUSY     = busy_q;
    assign RBO      = q_zero & ENT;

endmodule

// File: tb/tb_ls161_down_timer.sv
// Directed testbench for ls161_down_timer.
// Single DUT for functional scenarios plus a two-stage cascade.
module tb_ls161_down_timer;

    logic       clk;
    logic       clr;
    logic [3:0] d;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic       reload;
    logic [3:0] q;
    logic       rbo;
    logic       tc;
    logic       busy;

    logic       c_clr;
    logic [3:0] c_d;
    logic       c_load_n;
    logic       c_en;
    logic       c_lo_reload;
    logic       c_hi_reload;
    logic [3:0] lo_q;
    logic       lo_rbo;
    logic       lo_tc;
    logic       lo_busy;
    logic [3:0] hi_q;
    logic       hi_rbo;
    logic       hi_tc;
    logic       hi_busy;

    int checks;
    int errors;

    ls161_down_timer #(.WIDTH(4)) u_dut (
        .CLK      (clk),
        .CLR      (clr),
        .D        (d),
        .LOAD_n   (load_n),
        .ENP      (enp),
        .ENT      (ent),
        .RELOAD   (reload),
        .Q        (q),
        .RBO      (rbo),
        .TC_PULSE (tc),
        .BUSY     (busy)
    );

    ls161_down_timer #(.WIDTH(4)) u_lo (
        .CLK      (clk),
        .CLR      (c_clr),
        .D        (c_d),
        .LOAD_n   (c_load_n),
        .ENP      (c_en),
        .ENT      (c_en),
        .RELOAD   (c_lo_reload),
        .Q        (lo_q),
        .RBO      (lo_rbo),
        .TC_PULSE (lo_tc),
        .BUSY     (lo_busy)
    );

    ls161_down_timer #(.WIDTH(4)) u_hi (
        .CLK      (clk),
        .CLR      (c_clr),
        .D        (c_d),
        .LOAD_n   (c_load_n),
        .ENP      (c_en),
        .ENT      (lo_rbo),
        .RELOAD   (c_hi_reload),
        .Q        (hi_q),
        .RBO      (hi_rbo),
        .TC_PULSE (hi_tc),
        .BUSY     (hi_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string nm, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, act, exp);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; d = 4'hA; load_n = 1'b0;
        enp = 1'b1; ent = 1'b1; reload = 1'b0;
        step();
        step();
        chk_q("reset_q", q, 4'h0);
        chk_b("reset_busy", busy, 1'b0);
        chk_b("reset_tc", tc, 1'b0);
        chk_b("reset_rbo_ent1", rbo, 1'b1);
        ent = 1'b0;
        #1;
        chk_b("reset_rbo_ent0", rbo, 1'b0);
        clr = 1'b0; load_n = 1'b1; ent = 1'b1;
        step();
        chk_q("idle_hold_q", q, 4'h0);
        chk_b("idle_busy", busy, 1'b0);
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_q [3] = '{4'd2, 4'd1, 4'd0};
        d = 4'd3; load_n = 1'b0; reload = 1'b0;
        enp = 1'b1; ent = 1'b1;
        step();
        load_n = 1'b1;
        chk_q("os_load_q", q, 4'd3);
        chk_b("os_load_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_q("os_cnt_q", q, exp_q[i]);
            chk_b("os_cnt_tc", tc, 1'b0);
            chk_b("os_cnt_busy", busy, 1'b1);
        end
        step();
        chk_q("os_tc_q", q, 4'd0);
        chk_b("os_tc_pulse", tc, 1'b1);
        chk_b("os_tc_busy", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_q("os_done_q", q, 4'd0);
            chk_b("os_done_tc", tc, 1'b0);
            chk_b("os_done_busy", busy, 1'b0);
        end
        chk_b("os_done_rbo", rbo, 1'b1);
    endtask

    task automatic test_auto_reload();
        logic [3:0] exp_q [12] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2,
                                   4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
        logic exp_tc [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        d = 4'd2; load_n = 1'b0; reload = 1'b1;
        step();
        load_n = 1'b1;
        chk_q("ar_load_q", q, 4'd2);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_q("ar_q", q, exp_q[i]);
            chk_b("ar_tc", tc, exp_tc[i]);
            chk_b("ar_busy", busy, 1'b1);
        end
    endtask

    task automatic test_enable_gating();
        d = 4'd5; load_n = 1'b0; reload = 1'b0;
        enp = 1'b1; ent = 1'b1;
        step();
        load_n = 1'b1;
        step();
        chk_q("eg_first_q", q, 4'd4);
        enp = 1'b0;
        step();
        chk_q("eg_enp0_q1", q, 4'd4);
        step();
        chk_q("eg_enp0_q2", q, 4'd4);
        chk_b("eg_enp0_tc", tc, 1'b0);
        enp = 1'b1; ent = 1'b0;
        step();
        chk_q("eg_ent0_q", q, 4'd4);
        chk_b("eg_ent0_rbo", rbo, 1'b0);
        ent = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            step();
            chk_q("eg_resume_q", q, 4'(i));
        end
        ent = 1'b0;
        #1;
        chk_b("eg_zero_ent0_rbo", rbo, 1'b0);
        step();
        chk_q("eg_zero_hold_q", q, 4'd0);
        chk_b("eg_zero_hold_tc", tc, 1'b0);
        chk_b("eg_zero_hold_busy", busy, 1'b1);
        ent = 1'b1;
        enp = 1'b0;
        #1;
        chk_b("eg_zero_rbo_enp0", rbo, 1'b1);
        enp = 1'b1;
        step();
        chk_b("eg_final_tc", tc, 1'b1);
        chk_b("eg_final_busy", busy, 1'b0);
    endtask

    task automatic test_load_vs_tc();
        d = 4'd1; load_n = 1'b0; reload = 1'b1;
        enp = 1'b1; ent = 1'b1;
        step();
        load_n = 1'b1;
        step();
        chk_q("lt_at_zero_q", q, 4'd0);
        d = 4'd7; load_n = 1'b0;
        step();
        load_n = 1'b1;
        chk_q("lt_load_q", q, 4'd7);
        chk_b("lt_load_tc", tc, 1'b0);
        chk_b("lt_load_busy", busy, 1'b1);
        step();
        chk_q("lt_after_q", q, 4'd6);
    endtask

    task automatic test_clr_mid();
        d = 4'd9; load_n = 1'b0; reload = 1'b1;
        step();
        load_n = 1'b1;
        step();
        step();
        chk_q("cm_pre_q", q, 4'd7);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_q("cm_q", q, 4'd0);
        chk_b("cm_busy", busy, 1'b0);
        chk_b("cm_tc", tc, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_q("cm_idle_q", q, 4'd0);
            chk_b("cm_idle_tc", tc, 1'b0);
        end
    endtask

    task automatic test_r_zero();
        d = 4'd0; load_n = 1'b0; reload = 1'b1;
        step();
        load_n = 1'b1;
        chk_q("rz_load_q", q, 4'd0);
        chk_b("rz_load_tc", tc, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_q("rz_q", q, 4'd0);
            chk_b("rz_tc", tc, 1'b1);
            chk_b("rz_busy", busy, 1'b1);
        end
    endtask

    // Low stage auto-reloads from R=1, so it borrows every second edge;
    // the high stage (one-shot) steps only on those borrow edges.
    task automatic test_cascade();
        logic [3:0] exp_lo [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic [3:0] exp_hi [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic exp_htc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        c_clr = 1'b1; c_load_n = 1'b1; c_en = 1'b0;
        c_d = 4'h1; c_lo_reload = 1'b1; c_hi_reload = 1'b0;
        step();
        c_clr = 1'b0; c_load_n = 1'b0;
        step();
        c_load_n = 1'b1; c_en = 1'b1;
        chk_q("cs_load_lo", lo_q, 4'h1);
        chk_q("cs_load_hi", hi_q, 4'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_q("cs_lo_q", lo_q, exp_lo[i]);
            chk_q("cs_hi_q", hi_q, exp_hi[i]);
            chk_b("cs_hi_tc", hi_tc, exp_htc[i]);
        end
        chk_b("cs_hi_busy", hi_busy, 1'b0);
        chk_b("cs_lo_busy", lo_busy, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b1; d = '0; load_n = 1'b1;
        enp = 1'b0; ent = 1'b0; reload = 1'b0;
        c_clr = 1'b1; c_d = '0; c_load_n = 1'b1;
        c_en = 1'b0; c_lo_reload = 1'b0; c_hi_reload = 1'b0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_gating();
        test_load_vs_tc();
        test_clr_mid();
        test_r_zero();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
